// File: rtl/br_flow_xbar_pkg.sv
// Shared definitions for the flow crossbar blocks.
// - clamp_count_width: bit width needed to hold an occupancy of 0..depth.
//   The result is never smaller than 1 bit.
package br_flow_xbar_pkg;

    function automatic int unsigned clamp_count_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/br_flow_xbar_push_fifo_flops.sv
// Storage array for the push FIFO: Depth entries of Width bits.
// Ports:
//   clk_i      in  clock
//   wr_en_i    in  write strobe
//   wr_addr_i  in  write entry index
//   wr_data_i  in  write payload
//   rd_addr_i  in  read entry index (asynchronous read)
//   rd_data_o  out read payload
// Data flops carry no reset; occupancy tracking in the parent guards validity.
module br_flow_xbar_push_fifo_flops #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned Width     = 1,
    parameter int unsigned AddrWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [Width-1:0]     wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [Width-1:0]     rd_data_o
);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [Depth-1:0][Width-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/br_flow_xbar_push_fifo.sv
// Ingress FIFO for one push port of the flow crossbar.
// Buffers payload plus destination ID, decouples the source from crossbar
// backpressure and exports per-destination counts of stored items.
// Ports:
//   clk, rst_n                                   clock, async active-low reset
//   push_ready/push_valid/push_data/push_dest_id source side handshake
//   pop_ready/pop_valid/pop_data/pop_dest_id     crossbar side handshake
//   full, empty, items                           occupancy status
//   dest_pending[d]                              stored items headed to dest d
module br_flow_xbar_push_fifo
    import br_flow_xbar_pkg::*;
#(
    parameter int unsigned Depth        = 2,
    parameter int unsigned Width        = 1,
    parameter int unsigned NumDests     = 2,
    parameter bit          EnableBypass = 1'b1,
    localparam int unsigned DestIdWidth = $clog2(NumDests),
    localparam int unsigned CountWidth  = clamp_count_width(Depth)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    output logic                                 push_ready,
    input  logic                                 push_valid,
    input  logic [Width-1:0]                     push_data,
    input  logic [DestIdWidth-1:0]               push_dest_id,
    input  logic                                 pop_ready,
    output logic                                 pop_valid,
    output logic [Width-1:0]                     pop_data,
    output logic [DestIdWidth-1:0]               pop_dest_id,
    output logic                                 full,
    output logic                                 empty,
    output logic [CountWidth-1:0]                items,
    output logic [NumDests-1:0][CountWidth-1:0]  dest_pending
);

    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned EntryWidth = Width + DestIdWidth;

    logic [PtrWidth-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0]               items_q, items_d;
    logic [NumDests-1:0][CountWidth-1:0] pend_q, pend_d;

    logic [EntryWidth-1:0] rd_entry;
    logic [Width-1:0]      head_data;
    logic [DestIdWidth-1:0] head_dest;
    logic bypass;
    logic push_fire;
    logic pop_fire;
    logic pass_thru;
    logic wr_en;
    logic rd_en;

    assign head_data = rd_entry[Width-1:0];
    assign head_dest = rd_entry[EntryWidth-1:Width];

    always_comb begin
        empty      = (items_q == '0);
        full       = (items_q == CountWidth'(Depth));
        // Gated by rst_n so the source sees no ready while reset is held.
        push_ready = rst_n & ~full;
        bypass     = EnableBypass & empty;

        pop_valid   = bypass ? push_valid : ~empty;
        pop_data    = bypass ? push_data : head_data;
        pop_dest_id = bypass ? push_dest_id : head_dest;

        push_fire = push_valid & push_ready;
        pop_fire  = pop_valid & pop_ready;
        // Cut-through: item leaves in the cycle it arrives and never touches storage.
        pass_thru = bypass & push_fire & pop_ready;
        wr_en     = push_fire & ~pass_thru;
        rd_en     = pop_fire & ~empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end

        items_d = items_q;
        if (wr_en && !rd_en) begin
            items_d = items_q + CountWidth'(1);
        end else if (rd_en && !wr_en) begin
            items_d = items_q - CountWidth'(1);
        end

        pend_d = pend_q;
        for (int d = 0; d < NumDests; d++) begin
            if (wr_en && (push_dest_id == DestIdWidth'(d)) &&
                !(rd_en && (head_dest == DestIdWidth'(d)))) begin
                pend_d[d] = pend_q[d] + CountWidth'(1);
            end else if (rd_en && (head_dest == DestIdWidth'(d)) &&
                         !(wr_en && (push_dest_id == DestIdWidth'(d)))) begin
                pend_d[d] = pend_q[d] - CountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            items_q  <= '0;
            pend_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            items_q  <= items_d;
            pend_q   <= pend_d;
        end
    end

    assign items        = items_q;
    assign dest_pending = pend_q;

    br_flow_xbar_push_fifo_flops #(
        .Depth     (Depth),
        .Width     (EntryWidth),
        .AddrWidth (PtrWidth)
    ) u_flops (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({push_dest_id, push_data}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

`ifndef SYNTHESIS
    int pend_sum;
    always_comb begin
        pend_sum = 0;
        for (int d = 0; d < NumDests; d++) begin
            pend_sum = pend_sum + int'(pend_q[d]);
        end
    end

    a_dest_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        push_valid |-> (32'(push_dest_id) < NumDests));
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full));
    a_items_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(items_q) <= Depth);
    a_sum_invariant: assert property (@(posedge clk) disable iff (!rst_n)
        pend_sum == int'(items_q));
`endif

endmodule

// File: tb/tb_br_flow_xbar_push_fifo.sv
// Directed bench for br_flow_xbar_push_fifo.
// Instance a: Depth=2, no bypass. Instance b: Depth=3, bypass enabled.
module tb_br_flow_xbar_push_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance a
    logic            push_ready_a, push_valid_a, pop_ready_a, pop_valid_a;
    logic [7:0]      push_data_a, pop_data_a;
    logic            push_dest_a, pop_dest_a;
    logic            full_a, empty_a;
    logic [1:0]      items_a;
    logic [1:0][1:0] dp_a;

    // Instance b
    logic            push_ready_b, push_valid_b, pop_ready_b, pop_valid_b;
    logic [7:0]      push_data_b, pop_data_b;
    logic            push_dest_b, pop_dest_b;
    logic            full_b, empty_b;
    logic [1:0]      items_b;
    logic [1:0][1:0] dp_b;

    int n_checks = 0;
    int n_errors = 0;
    int push_idx;
    int pop_idx;

    br_flow_xbar_push_fifo #(
        .Depth(2), .Width(8), .NumDests(2), .EnableBypass(1'b0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .push_ready(push_ready_a), .push_valid(push_valid_a),
        .push_data(push_data_a), .push_dest_id(push_dest_a),
        .pop_ready(pop_ready_a), .pop_valid(pop_valid_a),
        .pop_data(pop_data_a), .pop_dest_id(pop_dest_a),
        .full(full_a), .empty(empty_a), .items(items_a), .dest_pending(dp_a)
    );

    br_flow_xbar_push_fifo #(
        .Depth(3), .Width(8), .NumDests(2), .EnableBypass(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .push_ready(push_ready_b), .push_valid(push_valid_b),
        .push_data(push_data_b), .push_dest_id(push_dest_b),
        .pop_ready(pop_ready_b), .pop_valid(pop_valid_b),
        .pop_data(pop_data_b), .pop_dest_id(pop_dest_b),
        .full(full_b), .empty(empty_b), .items(items_b), .dest_pending(dp_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        push_valid_a = 0; push_data_a = 0; push_dest_a = 0; pop_ready_a = 0;
        push_valid_b = 0; push_data_b = 0; push_dest_b = 0; pop_ready_b = 0;

        // Reset held
        #3;
        check_eq("rst_push_ready_low_a", 32'(push_ready_a), 0);
        check_eq("rst_push_ready_low_b", 32'(push_ready_b), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        check_eq("rst_push_ready_a", 32'(push_ready_a), 1);
        check_eq("rst_pop_valid_a", 32'(pop_valid_a), 0);
        check_eq("rst_full_a", 32'(full_a), 0);
        check_eq("rst_empty_a", 32'(empty_a), 1);
        check_eq("rst_items_a", 32'(items_a), 0);
        check_eq("rst_dp_a", 32'(dp_a), 0);
        check_eq("rst_items_b", 32'(items_b), 0);
        check_eq("rst_dp_b", 32'(dp_b), 0);

        // a: no-bypass, one cycle latency
        push_valid_a = 1; push_data_a = 8'hA5; push_dest_a = 1; pop_ready_a = 1;
        #1;
        check_eq("nobyp_pop_valid_same_cycle", 32'(pop_valid_a), 0);
        step();
        push_valid_a = 0;
        #1;
        check_eq("nobyp_pop_valid", 32'(pop_valid_a), 1);
        check_eq("nobyp_pop_data", 32'(pop_data_a), 32'hA5);
        check_eq("nobyp_pop_dest", 32'(pop_dest_a), 1);
        check_eq("nobyp_items", 32'(items_a), 1);
        check_eq("nobyp_dp1_before", 32'(dp_a[1]), 1);
        step();
        check_eq("nobyp_dp1_after", 32'(dp_a[1]), 0);
        check_eq("nobyp_empty_after", 32'(empty_a), 1);
        check_eq("nobyp_pop_valid_after", 32'(pop_valid_a), 0);
        pop_ready_a = 0;

        // b: bypass on empty
        push_valid_b = 1; push_data_b = 8'h3C; push_dest_b = 1; pop_ready_b = 1;
        #1;
        check_eq("byp_pop_valid", 32'(pop_valid_b), 1);
        check_eq("byp_pop_data", 32'(pop_data_b), 32'h3C);
        check_eq("byp_pop_dest", 32'(pop_dest_b), 1);
        step();
        push_valid_b = 0; pop_ready_b = 0;
        #1;
        check_eq("byp_items", 32'(items_b), 0);
        check_eq("byp_dp", 32'(dp_b), 0);
        check_eq("byp_empty", 32'(empty_b), 1);

        // b: fill to full with pop_ready low
        push_valid_b = 1; push_data_b = 8'h11; push_dest_b = 0; step();
        push_data_b = 8'h22; push_dest_b = 1; step();
        push_data_b = 8'h33; push_dest_b = 0; step();
        push_data_b = 8'h44; push_dest_b = 1;
        #1;
        check_eq("full_flag", 32'(full_b), 1);
        check_eq("full_push_ready", 32'(push_ready_b), 0);
        check_eq("full_items", 32'(items_b), 3);
        check_eq("full_dp0", 32'(dp_b[0]), 2);
        check_eq("full_dp1", 32'(dp_b[1]), 1);
        repeat (2) step();
        check_eq("full_hold_items", 32'(items_b), 3);
        check_eq("full_hold_pop_valid", 32'(pop_valid_b), 1);
        check_eq("full_hold_pop_data", 32'(pop_data_b), 32'h11);
        check_eq("full_hold_pop_dest", 32'(pop_dest_b), 0);

        // Drain to one item (0x33 dest 0)
        push_valid_b = 0; pop_ready_b = 1;
        step();
        check_eq("drain_head1", 32'(pop_data_b), 32'h22);
        step();
        check_eq("drain_head2", 32'(pop_data_b), 32'h33);
        check_eq("drain_items", 32'(items_b), 1);

        // Simultaneous push/pop, same dest
        push_valid_b = 1; push_data_b = 8'h55; push_dest_b = 0;
        step();
        check_eq("simul_same_items", 32'(items_b), 1);
        check_eq("simul_same_dp0", 32'(dp_b[0]), 1);
        check_eq("simul_same_dp1", 32'(dp_b[1]), 0);
        check_eq("simul_same_head", 32'(pop_data_b), 32'h55);
        // Push dest 1, pop dest 0
        push_data_b = 8'h66; push_dest_b = 1;
        step();
        check_eq("simul_diff_items", 32'(items_b), 1);
        check_eq("simul_diff_dp0", 32'(dp_b[0]), 0);
        check_eq("simul_diff_dp1", 32'(dp_b[1]), 1);
        check_eq("simul_diff_head", 32'(pop_data_b), 32'h66);
        check_eq("simul_diff_head_dest", 32'(pop_dest_b), 1);
        push_valid_b = 0;
        step();
        check_eq("simul_drained", 32'(empty_b), 1);

        // Wrap: 7 items with random pop_ready, checked in order
        push_idx = 0;
        pop_idx = 0;
        for (int cyc = 0; cyc < 80 && pop_idx < 7; cyc++) begin
            push_valid_b = (push_idx < 7);
            push_data_b  = 8'(8'h70 + push_idx);
            push_dest_b  = 1'(push_idx % 2);
            pop_ready_b  = 1'($urandom_range(0, 1));
            #1;
            check_eq("wrap_items", 32'(items_b), 32'(push_idx - pop_idx));
            check_eq("wrap_sum", 32'(dp_b[0]) + 32'(dp_b[1]), 32'(items_b));
            if (pop_valid_b && pop_ready_b) begin
                check_eq("wrap_data", 32'(pop_data_b), 32'(8'h70 + pop_idx));
                check_eq("wrap_dest", 32'(pop_dest_b), 32'(pop_idx % 2));
                pop_idx++;
            end
            if (push_valid_b && push_ready_b) begin
                push_idx++;
            end
            step();
        end
        check_eq("wrap_pop_count", 32'(pop_idx), 7);
        push_valid_b = 0; pop_ready_b = 0;

        // Reset mid-stream with two stored items
        push_valid_b = 1; push_data_b = 8'h81; push_dest_b = 0; step();
        push_data_b = 8'h82; push_dest_b = 1; step();
        push_valid_b = 0;
        #1;
        check_eq("mid_items_before", 32'(items_b), 2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pop_valid", 32'(pop_valid_b), 0);
        check_eq("mid_rst_items", 32'(items_b), 0);
        check_eq("mid_rst_dp", 32'(dp_b), 0);
        check_eq("mid_rst_empty", 32'(empty_b), 1);
        check_eq("mid_rst_push_ready", 32'(push_ready_b), 0);
        #2;
        rst_n = 1'b1;
        step();
        check_eq("mid_post_push_ready", 32'(push_ready_b), 1);
        check_eq("mid_post_pop_valid", 32'(pop_valid_b), 0);

        check_eq("end_empty_a", 32'(empty_a), 1);
        check_eq("end_empty_b", 32'(empty_b), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
